// File: rtl/core_bus_arbiter.sv
// Merges the CPU instruction and data request ports onto one single-beat memory channel.
// Latency: grant cycle, then at least one BUSY cycle; zero-wait memory gives one transaction per 2 cycles.
// Backpressure: requesters hold valid until data_ok; one outstanding request, completed by oresp_ready.
module core_bus_arbiter #(
    parameter int ADDR_W       = 64,
    parameter int DATA_W       = 64,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ireq_valid,
    input  logic [ADDR_W-1:0]     ireq_addr,
    output logic                  iresp_addr_ok,
    output logic                  iresp_data_ok,
    output logic [31:0]           iresp_data,
    input  logic                  dreq_valid,
    input  logic [ADDR_W-1:0]     dreq_addr,
    input  logic [2:0]            dreq_size,
    input  logic [DATA_W/8-1:0]   dreq_strobe,
    input  logic [DATA_W-1:0]     dreq_data,
    output logic                  dresp_addr_ok,
    output logic                  dresp_data_ok,
    output logic [DATA_W-1:0]     dresp_data,
    output logic                  oreq_valid,
    output logic [ADDR_W-1:0]     oreq_addr,
    output logic                  oreq_write,
    output logic [2:0]            oreq_size,
    output logic [DATA_W/8-1:0]   oreq_strobe,
    output logic [DATA_W-1:0]     oreq_data,
    input  logic                  oresp_ready,
    input  logic [DATA_W-1:0]     oresp_data
);
    localparam int          STRB_W     = DATA_W / 8;
    localparam logic [2:0]  SIZE_WORD  = 3'd2;
    localparam logic [3:0]  STREAK_MAX = 4'(MAX_D_STREAK);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        size;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
    } req_t;

    state_t     state_q, state_d;
    req_t       cap_q, cap_d;
    logic [3:0] streak_q, streak_d;
    logic       grant_d, grant_i, done, busy;

    always_comb begin
        state_d  = state_q;
        cap_d    = cap_q;
        streak_d = streak_q;
        grant_d  = 1'b0;
        grant_i  = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (dreq_valid && (!ireq_valid || streak_q < STREAK_MAX)) begin
                    grant_d      = 1'b1;
                    state_d      = BUSY_D;
                    cap_d.addr   = dreq_addr;
                    cap_d.size   = dreq_size;
                    cap_d.strobe = dreq_strobe;
                    cap_d.data   = dreq_data;
                    // Streak only grows while the ibus is actually waiting.
                    if (ireq_valid)
                        streak_d = (streak_q == 4'hF) ? 4'hF : streak_q + 4'd1;
                    else
                        streak_d = 4'd0;
                end else if (ireq_valid) begin
                    grant_i      = 1'b1;
                    state_d      = BUSY_I;
                    cap_d.addr   = ireq_addr;
                    cap_d.size   = SIZE_WORD;
                    cap_d.strobe = '0;
                    cap_d.data   = '0;
                    streak_d     = 4'd0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (oresp_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cap_q    <= '0;
            streak_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            cap_q    <= cap_d;
            streak_q <= streak_d;
        end
    end

    assign busy = (state_q != IDLE);

    // Handshakes are masked during reset so an abandoned transaction never completes.
    assign dresp_addr_ok = grant_d && !rst;
    assign iresp_addr_ok = grant_i && !rst;
    assign dresp_data_ok = done && (state_q == BUSY_D) && !rst;
    assign iresp_data_ok = done && (state_q == BUSY_I) && !rst;

    assign dresp_data = dresp_data_ok ? oresp_data : '0;
    assign iresp_data = !iresp_data_ok ? 32'd0 :
                        (cap_q.addr[2] ? oresp_data[63:32] : oresp_data[31:0]);

    assign oreq_valid  = busy;
    assign oreq_addr   = busy ? cap_q.addr   : '0;
    assign oreq_size   = busy ? cap_q.size   : 3'd0;
    assign oreq_strobe = busy ? cap_q.strobe : '0;
    assign oreq_data   = busy ? cap_q.data   : '0;
    assign oreq_write  = busy && (|cap_q.strobe);
endmodule

// File: tb/tb_core_bus_arbiter.sv
// Self-checking bench for core_bus_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level model of the grant and completion rules.
module tb_core_bus_arbiter;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int MAXS   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ireq_valid;
    logic [ADDR_W-1:0] ireq_addr;
    logic              iresp_addr_ok, iresp_data_ok;
    logic [31:0]       iresp_data;
    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic [2:0]        dreq_size;
    logic [7:0]        dreq_strobe;
    logic [DATA_W-1:0] dreq_data;
    logic              dresp_addr_ok, dresp_data_ok;
    logic [DATA_W-1:0] dresp_data;
    logic              oreq_valid, oreq_write;
    logic [ADDR_W-1:0] oreq_addr;
    logic [2:0]        oreq_size;
    logic [7:0]        oreq_strobe;
    logic [DATA_W-1:0] oreq_data;
    logic              oresp_ready;
    logic [DATA_W-1:0] oresp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .oreq_valid(oreq_valid), .oreq_addr(oreq_addr), .oreq_write(oreq_write),
        .oreq_size(oreq_size), .oreq_strobe(oreq_strobe), .oreq_data(oreq_data),
        .oresp_ready(oresp_ready), .oresp_data(oresp_data)
    );

    task automatic clear_inputs();
        ireq_valid = 0; ireq_addr = '0;
        dreq_valid = 0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
        oresp_ready = 0; oresp_data = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        ireq_valid = 1; dreq_valid = 1; oresp_ready = 1; oresp_data = 64'hFFFF_FFFF_FFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok} !== 4'b0)
            begin errors++; $display("FAIL reset_handshake got %b want 0000",
                {iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok}); end
        checks++;
        if (oreq_valid !== 1'b0 || oreq_addr !== '0 || oreq_write !== 1'b0 || oreq_strobe !== '0 ||
            oreq_data !== '0 || oreq_size !== '0 || iresp_data !== '0 || dresp_data !== '0)
            begin errors++; $display("FAIL reset_outputs got oreq_valid=%b addr=%h data=%h want all 0",
                oreq_valid, oreq_addr, oreq_data); end
        @(posedge clk); #1;
        rst = 0;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (oreq_valid !== 1'b0 || dresp_addr_ok !== 1'b0 || iresp_addr_ok !== 1'b0)
            begin errors++; $display("FAIL reset_idle got oreq_valid=%b want 0", oreq_valid); end
    endtask

    task automatic test_ifetch();
        do_reset();
        @(posedge clk); #1;
        ireq_valid = 1; ireq_addr = 64'h8000_0004;
        @(negedge clk);
        checks++;
        if (iresp_addr_ok !== 1'b1 || dresp_addr_ok !== 1'b0 || oreq_valid !== 1'b0)
            begin errors++; $display("FAIL ifetch_grant got i_addr_ok=%b oreq_valid=%b want 1 0",
                iresp_addr_ok, oreq_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (oreq_valid !== 1'b1 || oreq_addr !== 64'h8000_0004 || oreq_write !== 1'b0 ||
            oreq_size !== 3'd2 || oreq_strobe !== 8'h00 || oreq_data !== '0 || iresp_addr_ok !== 1'b0)
            begin errors++; $display("FAIL ifetch_issue got v=%b addr=%h w=%b size=%0d want 1 80000004 0 2",
                oreq_valid, oreq_addr, oreq_write, oreq_size); end
        @(posedge clk); #1;
        oresp_ready = 1; oresp_data = 64'h1111_2222_3333_4444;
        @(negedge clk);
        checks++;
        if (iresp_data_ok !== 1'b1 || iresp_data !== 32'h1111_2222 || dresp_data_ok !== 1'b0)
            begin errors++; $display("FAIL ifetch_data got ok=%b data=%h want 1 11112222",
                iresp_data_ok, iresp_data); end
        @(posedge clk); #1;
        oresp_ready = 0; ireq_valid = 0;
        @(negedge clk);
        checks++;
        if (oreq_valid !== 1'b0 || iresp_data_ok !== 1'b0 || iresp_data !== 32'd0)
            begin errors++; $display("FAIL ifetch_after got v=%b ok=%b data=%h want 0 0 0",
                oreq_valid, iresp_data_ok, iresp_data); end
    endtask

    task automatic test_dwrite();
        int oks = 0;
        do_reset();
        @(posedge clk); #1;
        dreq_valid = 1; dreq_addr = 64'h100; dreq_size = 3'd2; dreq_strobe = 8'h0F;
        dreq_data = 64'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (dresp_addr_ok !== 1'b1 || iresp_addr_ok !== 1'b0)
            begin errors++; $display("FAIL dwrite_grant got d_addr_ok=%b want 1", dresp_addr_ok); end
        for (int k = 0; k <= 3; k++) begin
            @(posedge clk); #1;
            oresp_ready = (k == 3);
            @(negedge clk);
            checks++;
            if (oreq_valid !== 1'b1 || oreq_write !== 1'b1 || oreq_strobe !== 8'h0F ||
                oreq_data !== 64'hDEAD_BEEF || oreq_addr !== 64'h100)
                begin errors++; $display("FAIL dwrite_issue k=%0d got v=%b w=%b strb=%h data=%h want 1 1 0f deadbeef",
                    k, oreq_valid, oreq_write, oreq_strobe, oreq_data); end
            checks++;
            if (dresp_data_ok !== (k == 3))
                begin errors++; $display("FAIL dwrite_latency k=%0d got ok=%b want %b",
                    k, dresp_data_ok, (k == 3)); end
            if (dresp_data_ok === 1'b1) oks++;
        end
        @(posedge clk); #1;
        oresp_ready = 0; dreq_valid = 0;
        @(negedge clk);
        if (dresp_data_ok === 1'b1) oks++;
        checks++;
        if (oks != 1 || oreq_valid !== 1'b0)
            begin errors++; $display("FAIL dwrite_once got %0d data_ok pulses v=%b want 1 0", oks, oreq_valid); end
    endtask

    task automatic test_both_valid();
        do_reset();
        @(posedge clk); #1;
        ireq_valid = 1; ireq_addr = 64'h2000;
        dreq_valid = 1; dreq_addr = 64'h3000; dreq_strobe = 8'h00; dreq_size = 3'd3;
        @(negedge clk);
        checks++;
        if (dresp_addr_ok !== 1'b1 || iresp_addr_ok !== 1'b0)
            begin errors++; $display("FAIL both_first got d=%b i=%b want 1 0", dresp_addr_ok, iresp_addr_ok); end
        @(posedge clk); #1;
        oresp_ready = 1; oresp_data = 64'h0123_4567_89AB_CDEF;
        @(negedge clk);
        checks++;
        if (dresp_data_ok !== 1'b1 || dresp_data !== 64'h0123_4567_89AB_CDEF || iresp_addr_ok !== 1'b0)
            begin errors++; $display("FAIL both_dcomplete got ok=%b data=%h i_addr_ok=%b want 1 0123456789abcdef 0",
                dresp_data_ok, dresp_data, iresp_addr_ok); end
        @(posedge clk); #1;
        oresp_ready = 0; dreq_valid = 0;
        @(negedge clk);
        checks++;
        if (iresp_addr_ok !== 1'b1 || dresp_addr_ok !== 1'b0)
            begin errors++; $display("FAIL both_second got i=%b d=%b want 1 0", iresp_addr_ok, dresp_addr_ok); end
        @(posedge clk); #1;
        oresp_ready = 1; oresp_data = 64'hAAAA_BBBB_CCCC_DDDD;
        @(negedge clk);
        checks++;
        if (iresp_data_ok !== 1'b1 || iresp_data !== 32'hCCCC_DDDD)
            begin errors++; $display("FAIL both_icomplete got ok=%b data=%h want 1 ccccdddd",
                iresp_data_ok, iresp_data); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_starvation();
        int  g = 0;
        bit  resp_next = 0;
        bit  exp_i;
        do_reset();
        @(posedge clk); #1;
        ireq_valid = 1; ireq_addr = 64'h1000;
        dreq_valid = 1; dreq_addr = 64'h4000; dreq_strobe = 8'h00; dreq_size = 3'd3;
        for (int c = 0; c < 40 && g < 10; c++) begin
            oresp_ready = resp_next;
            oresp_data  = {$urandom, $urandom};
            @(negedge clk);
            checks++;
            if (dresp_addr_ok === 1'b1 && iresp_addr_ok === 1'b1)
                begin errors++; $display("FAIL starve_overlap cycle %0d got both addr_ok want one", c); end
            resp_next = 0;
            if (dresp_addr_ok === 1'b1 || iresp_addr_ok === 1'b1) begin
                exp_i = ((g % (MAXS + 1)) == MAXS);
                checks++;
                if (iresp_addr_ok !== exp_i || dresp_addr_ok !== !exp_i)
                    begin errors++; $display("FAIL starve_order grant %0d got i=%b d=%b want i=%b",
                        g, iresp_addr_ok, dresp_addr_ok, exp_i); end
                g++;
                resp_next = 1;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (g != 10)
            begin errors++; $display("FAIL starve_timeout got %0d grants want 10", g); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(posedge clk); #1;
        dreq_valid = 1; dreq_addr = 64'h40; dreq_strobe = 8'hFF; dreq_size = 3'd3; dreq_data = 64'h77;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (oreq_valid !== 1'b1 || oreq_addr !== 64'h40)
            begin errors++; $display("FAIL rstmid_busy got v=%b addr=%h want 1 40", oreq_valid, oreq_addr); end
        @(posedge clk); #1;
        rst = 1; oresp_ready = 1; oresp_data = 64'h5555;
        @(negedge clk);
        checks++;
        if (dresp_data_ok !== 1'b0 || dresp_addr_ok !== 1'b0 || dresp_data !== '0)
            begin errors++; $display("FAIL rstmid_ok got d_data_ok=%b addr_ok=%b want 0 0",
                dresp_data_ok, dresp_addr_ok); end
        @(posedge clk); #1;
        rst = 0; oresp_ready = 0; dreq_valid = 0;
        @(negedge clk);
        checks++;
        if (oreq_valid !== 1'b0 || dresp_data_ok !== 1'b0)
            begin errors++; $display("FAIL rstmid_drop got v=%b ok=%b want 0 0", oreq_valid, dresp_data_ok); end
        @(posedge clk); #1;
        dreq_valid = 1; dreq_addr = 64'h200; dreq_strobe = 8'h00; dreq_size = 3'd3;
        @(negedge clk);
        checks++;
        if (dresp_addr_ok !== 1'b1)
            begin errors++; $display("FAIL rstmid_regrant got addr_ok=%b want 1", dresp_addr_ok); end
        @(posedge clk); #1;
        oresp_ready = 1; oresp_data = 64'hCAFE_F00D_0000_1234;
        @(negedge clk);
        checks++;
        if (oreq_valid !== 1'b1 || oreq_addr !== 64'h200 || oreq_write !== 1'b0 ||
            dresp_data_ok !== 1'b1 || dresp_data !== 64'hCAFE_F00D_0000_1234)
            begin errors++; $display("FAIL rstmid_read got v=%b addr=%h w=%b ok=%b data=%h want 1 200 0 1 cafef00d00001234",
                oreq_valid, oreq_addr, oreq_write, dresp_data_ok, dresp_data); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_spurious_and_hold();
        do_reset();
        @(posedge clk); #1;
        oresp_ready = 1; oresp_data = 64'h9999;
        @(negedge clk);
        checks++;
        if (iresp_data_ok !== 1'b0 || dresp_data_ok !== 1'b0 || oreq_valid !== 1'b0 || dresp_data !== '0)
            begin errors++; $display("FAIL spurious_ok got i=%b d=%b v=%b want 0 0 0",
                iresp_data_ok, dresp_data_ok, oreq_valid); end
        @(posedge clk); #1;
        oresp_ready = 0;
        dreq_valid = 1; dreq_addr = 64'h300; dreq_size = 3'd1; dreq_strobe = 8'h03; dreq_data = 64'h55AA;
        @(negedge clk);
        checks++;
        if (dresp_addr_ok !== 1'b1 || oreq_valid !== 1'b0)
            begin errors++; $display("FAIL spurious_state got addr_ok=%b v=%b want 1 0", dresp_addr_ok, oreq_valid); end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            dreq_addr = {$urandom, $urandom}; dreq_strobe = 8'hF0; dreq_size = 3'd3;
            dreq_data = {$urandom, $urandom};
            @(negedge clk);
            checks++;
            if (oreq_addr !== 64'h300 || oreq_strobe !== 8'h03 || oreq_size !== 3'd1 || oreq_data !== 64'h55AA)
                begin errors++; $display("FAIL hold_fields k=%0d got addr=%h strb=%h size=%0d data=%h want 300 03 1 55aa",
                    k, oreq_addr, oreq_strobe, oreq_size, oreq_data); end
        end
        @(posedge clk); #1;
        oresp_ready = 1;
        @(negedge clk);
        checks++;
        if (dresp_data_ok !== 1'b1)
            begin errors++; $display("FAIL hold_complete got ok=%b want 1", dresp_data_ok); end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic test_random();
        int          streak = 0;
        int          outst  = 0;
        int          lat    = 0;
        bit          i_pend = 0, d_pend = 0;
        logic [63:0] i_addr, d_addr, d_wdat, e_addr, e_data, rdata;
        logic [2:0]  d_size, e_size;
        logic [7:0]  d_strb, e_strb;
        logic        gd, gi, x_iok, x_dok;
        logic [31:0] x_idat;
        logic [63:0] x_ddat;
        i_addr = '0; d_addr = '0; d_wdat = '0; d_size = '0; d_strb = '0;
        e_addr = '0; e_data = '0; e_size = '0; e_strb = '0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; i_addr = {$urandom, $urandom} & ~64'h3;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_addr = {$urandom, $urandom}; d_size = 3'($urandom_range(0, 3));
                d_strb = $urandom_range(0, 1) ? 8'($urandom) : 8'h00; d_wdat = {$urandom, $urandom};
            end
            if (outst == 2) begin d_addr = {$urandom, $urandom}; d_strb = 8'($urandom); d_wdat = {$urandom, $urandom}; end
            if (outst == 1) i_addr = {$urandom, $urandom};
            ireq_valid = i_pend; ireq_addr = i_addr;
            dreq_valid = d_pend; dreq_addr = d_addr; dreq_size = d_size; dreq_strobe = d_strb; dreq_data = d_wdat;
            rdata = {$urandom, $urandom};
            oresp_data = rdata;
            if (outst != 0) begin
                oresp_ready = (lat == 0);
                if (lat > 0) lat--;
            end else begin
                oresp_ready = ($urandom_range(0, 7) == 0);
            end
            @(negedge clk);
            if (outst == 0) begin
                gd = d_pend && (!i_pend || streak < MAXS);
                gi = !gd && i_pend;
                checks++;
                if (dresp_addr_ok !== gd || iresp_addr_ok !== gi)
                    begin errors++; $display("FAIL rnd_grant cyc %0d got d=%b i=%b want d=%b i=%b",
                        c, dresp_addr_ok, iresp_addr_ok, gd, gi); end
                checks++;
                if (oreq_valid !== 1'b0 || iresp_data_ok !== 1'b0 || dresp_data_ok !== 1'b0 ||
                    iresp_data !== '0 || dresp_data !== '0)
                    begin errors++; $display("FAIL rnd_idle cyc %0d got v=%b iok=%b dok=%b want 0 0 0",
                        c, oreq_valid, iresp_data_ok, dresp_data_ok); end
                if (gd) begin
                    streak = i_pend ? ((streak >= 15) ? 15 : streak + 1) : 0;
                    outst = 2; e_addr = d_addr; e_size = d_size; e_strb = d_strb; e_data = d_wdat;
                    lat = $urandom_range(0, 3);
                end else if (gi) begin
                    streak = 0;
                    outst = 1; e_addr = i_addr; e_size = 3'd2; e_strb = 8'h00; e_data = '0;
                    lat = $urandom_range(0, 3);
                end
            end else begin
                checks++;
                if (oreq_valid !== 1'b1 || oreq_addr !== e_addr || oreq_size !== e_size ||
                    oreq_strobe !== e_strb || oreq_data !== e_data || oreq_write !== (e_strb != 0))
                    begin errors++; $display("FAIL rnd_issue cyc %0d got v=%b addr=%h strb=%h want 1 %h %h",
                        c, oreq_valid, oreq_addr, oreq_strobe, e_addr, e_strb); end
                checks++;
                if (iresp_addr_ok !== 1'b0 || dresp_addr_ok !== 1'b0)
                    begin errors++; $display("FAIL rnd_busy_grant cyc %0d got i=%b d=%b want 0 0",
                        c, iresp_addr_ok, dresp_addr_ok); end
                x_iok  = (outst == 1) && oresp_ready;
                x_dok  = (outst == 2) && oresp_ready;
                x_idat = x_iok ? (e_addr[2] ? rdata[63:32] : rdata[31:0]) : 32'd0;
                x_ddat = x_dok ? rdata : 64'd0;
                checks++;
                if (iresp_data_ok !== x_iok || dresp_data_ok !== x_dok ||
                    iresp_data !== x_idat || dresp_data !== x_ddat)
                    begin errors++; $display("FAIL rnd_resp cyc %0d got iok=%b dok=%b idat=%h ddat=%h want %b %b %h %h",
                        c, iresp_data_ok, dresp_data_ok, iresp_data, dresp_data, x_iok, x_dok, x_idat, x_ddat); end
                if (oresp_ready) begin
                    if (outst == 1) i_pend = 0; else d_pend = 0;
                    outst = 0;
                end
            end
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_ifetch();
        test_dwrite();
        test_both_valid();
        test_starvation();
        test_reset_mid();
        test_spurious_and_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
